spi_master_multi: RTL and testbench

//  Parametrised SPI master for the rv32e min-MCU peripheral bus; successor to the fixed 2-CS, mode-0 byte SPI.

---
 rtl/spi_master_multi.sv | 145 ++++++++++++++
 tb/tb_spi_master_multi.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/spi_master_multi.sv
// spi_master_multi: SPI master with N chip selects, 1..MAX_BYTES transfers, runtime CPOL/CPHA and SCLK divider
// Ports: clk/rst (async active-high); start/busy/done CPU handshake; cs_sel, num_bytes, cpol, cpha,
//   clk_div, tx_data latched at start; rx_data valid with done; sclk/mosi/cs_n/miso pad side.
module spi_master_multi #(
  parameter int NUM_CS = 2,
  parameter int MAX_BYTES = 4,
  parameter int DIV_WIDTH = 8,
  localparam int CSW = NUM_CS > 1 ? $clog2(NUM_CS) : 1,
  localparam int NBW = $clog2(MAX_BYTES + 1),
  localparam int DW = 8 * MAX_BYTES
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CSW-1:0]       cs_sel,
  input  logic [NBW-1:0]       num_bytes,
  input  logic                 cpol,
  input  logic                 cpha,
  input  logic [DIV_WIDTH-1:0] clk_div,
  input  logic [DW-1:0]        tx_data,
  output logic                 busy,
  output logic                 done,
  output logic [DW-1:0]        rx_data,
  output logic                 sclk,
  output logic                 mosi,
  output logic [NUM_CS-1:0]    cs_n,
  input  logic                 miso
);
  localparam int HPW = $clog2(16 * MAX_BYTES);
  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;
  state_t state_q, state_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d, div_q, div_d;
  logic [HPW-1:0] hp_q, hp_d, hp_last;
  logic [NBW-1:0] nb_q, nb_d, nb_in;
  logic cpol_q, cpol_d, cpha_q, cpha_d;
  logic [DW-1:0] tx_q, tx_d, rx_sr_q, rx_sr_d, rx_q, rx_d, tx_al;
  logic sclk_q, sclk_d, mosi_q, mosi_d, busy_q, busy_d, done_q, done_d;
  logic [NUM_CS-1:0] cs_n_q, cs_n_d;
  logic tick, go, smp, drv;
  assign tick = cnt_q == div_q;
  assign nb_in = num_bytes == '0 ? NBW'(1) : num_bytes > NBW'(MAX_BYTES) ? NBW'(MAX_BYTES) : num_bytes;
  assign tx_al = tx_data << {NBW'(MAX_BYTES) - nb_in, 3'b000};
  assign go = start && state_q == IDLE && ({1'b0, cs_sel} < (CSW + 1)'(NUM_CS));
  assign hp_last = HPW'({nb_q, 4'b0000} - (NBW + 4)'(1));
  // even half-period index ends on a leading edge; the edge after the final sample never drives
  assign smp = ~hp_q[0] ^ cpha_q;
  assign drv = ~smp && hp_q != hp_last;
  always_comb begin
    state_d = state_q;
    cnt_d = tick ? '0 : cnt_q + DIV_WIDTH'(1);
    div_d = div_q;
    hp_d = hp_q;
    nb_d = nb_q;
    cpol_d = cpol_q;
    cpha_d = cpha_q;
    tx_d = tx_q;
    rx_sr_d = rx_sr_q;
    rx_d = rx_q;
    sclk_d = sclk_q;
    mosi_d = mosi_q;
    busy_d = busy_q;
    done_d = 1'b0;
    cs_n_d = cs_n_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        sclk_d = go ? cpol : cpol_q;
        if (go) begin
          state_d = SETUP;
          busy_d = 1'b1;
          cpol_d = cpol;
          cpha_d = cpha;
          div_d = clk_div;
          nb_d = nb_in;
          hp_d = '0;
          rx_sr_d = '0;
          cs_n_d = ~(NUM_CS'(1) << cs_sel);
          mosi_d = cpha ? mosi_q : tx_al[DW-1];
          tx_d = cpha ? tx_al : tx_al << 1;
        end
      end
      SETUP: state_d = tick ? SHIFT : SETUP;
      SHIFT: begin
        if (tick) begin
          sclk_d = ~sclk_q;
          hp_d = hp_q + HPW'(1);
          rx_sr_d = smp ? {rx_sr_q[DW-2:0], miso} : rx_sr_q;
          mosi_d = drv ? tx_q[DW-1] : mosi_q;
          tx_d = drv ? tx_q << 1 : tx_q;
          state_d = hp_q == hp_last ? HOLD : SHIFT;
        end
      end
      HOLD: begin
        if (tick) begin
          state_d = IDLE;
          cs_n_d = '1;
          rx_d = rx_sr_q;
          done_d = 1'b1;
          busy_d = 1'b0;
        end
      end
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      div_q <= '0;
      hp_q <= '0;
      nb_q <= NBW'(1);
      cpol_q <= 1'b0;
      cpha_q <= 1'b0;
      tx_q <= '0;
      rx_sr_q <= '0;
      rx_q <= '0;
      sclk_q <= 1'b0;
      mosi_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      cs_n_q <= '1;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      div_q <= div_d;
      hp_q <= hp_d;
      nb_q <= nb_d;
      cpol_q <= cpol_d;
      cpha_q <= cpha_d;
      tx_q <= tx_d;
      rx_sr_q <= rx_sr_d;
      rx_q <= rx_d;
      sclk_q <= sclk_d;
      mosi_q <= mosi_d;
      busy_q <= busy_d;
      done_q <= done_d;
      cs_n_q <= cs_n_d;
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign rx_data = rx_q;
  assign sclk = sclk_q;
  assign mosi = mosi_q;
  assign cs_n = cs_n_q;
endmodule

// File: tb/tb_spi_master_multi.sv
// tb_spi_master_multi: scoreboard bench for spi_master_multi with a cycle-synchronous SPI slave model
module tb_spi_master_multi;
  logic clk = 0, rst = 1, start = 0, cpol = 0, cpha = 0, loop = 0, miso_s = 0;
  logic [0:0] cs_sel = '0;
  logic [2:0] num_bytes = '0;
  logic [7:0] clk_div = '0;
  logic [31:0] tx_data = '0, rx_data;
  logic busy, done, sclk, mosi, miso;
  logic [1:0] cs_n;
  int cyc = 0, n_chk = 0, n_fail = 0, last_exp = 0;
  typedef struct {
    logic [31:0] rx;
    logic [31:0] tx;
    int cyc;
    int edges;
    logic [2:0] cs;
  } exp_t;
  exp_t sbq[$];
  logic p_cpha = 0;
  int p_n = 1;
  logic [31:0] p_reply = '0;
  logic cs_prev = 0, cs_act, sclk_prev = 0, s_cpha = 0, cs_bad = 0;
  logic [31:0] s_sr = '0, s_rx = '0;
  logic [1:0] cs_seen = '1;
  int edges = 0;

  spi_master_multi dut (
    .clk(clk), .rst(rst), .start(start), .cs_sel(cs_sel), .num_bytes(num_bytes),
    .cpol(cpol), .cpha(cpha), .clk_div(clk_div), .tx_data(tx_data), .busy(busy),
    .done(done), .rx_data(rx_data), .sclk(sclk), .mosi(mosi), .cs_n(cs_n), .miso(miso)
  );

  assign miso = loop ? mosi : miso_s;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, want);
    end
  endtask

  // slave: reacts 1 time unit after each clk edge, so it never races the master's registers
  always @(posedge clk) begin
    #1;
    cs_act = ~&cs_n;
    if (cs_act && !cs_prev) begin
      s_cpha = p_cpha;
      s_sr = p_reply << (32 - 8 * p_n);
      s_rx = '0;
      edges = 0;
      cs_seen = cs_n;
      cs_bad = 0;
      if (!s_cpha) begin
        miso_s = s_sr[31];
        s_sr = s_sr << 1;
      end
    end else if (cs_act && cs_prev) begin
      if (cs_n != cs_seen) cs_bad = 1;
      if (sclk != sclk_prev) begin
        if ((edges % 2 == 0) ^ s_cpha) s_rx = {s_rx[30:0], mosi};
        else begin
          miso_s = s_sr[31];
          s_sr = s_sr << 1;
        end
        edges++;
      end
    end
    cs_prev = cs_act;
    sclk_prev = sclk;
  end

  always @(posedge clk) begin : mon
    exp_t e;
    #1;
    if (done) begin
      if (sbq.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        e = sbq.pop_front();
        chk("rx_data", rx_data, e.rx);
        chk("done_cycle", e.cyc == cyc ? 1 : cyc, 1);
        chk("sclk_edges", edges, e.edges);
        chk("mosi_word", s_rx, e.tx);
        chk("cs_n_pattern", {cs_bad, cs_seen}, e.cs);
        chk("busy_at_done", busy, 0);
      end
    end
  end

  task automatic xfer(input logic [0:0] cs, input logic [2:0] nb, input logic pol, input logic pha,
                      input logic [7:0] div, input logic [31:0] tx, input logic [31:0] reply,
                      input bit lb, input bit push, input bit hold, input int t0);
    int n;
    logic [63:0] m;
    exp_t e;
    @(posedge clk); #1;
    n = nb == 0 ? 1 : (nb > 4 ? 4 : int'(nb));
    m = (64'h1 << (8 * n)) - 64'h1;
    cs_sel = cs; num_bytes = nb; cpol = pol; cpha = pha; clk_div = div; tx_data = tx; loop = lb; start = 1;
    p_cpha = pha; p_n = n; p_reply = reply;
    e.tx = tx & m[31:0];
    e.rx = lb ? e.tx : reply & m[31:0];
    e.cyc = (t0 < 0 ? cyc + 1 : t0) + (2 + 16 * n) * (int'(div) + 1);
    e.edges = 16 * n;
    e.cs = {1'b0, ~(2'b01 << cs)};
    if (push) begin
      sbq.push_back(e);
      last_exp = e.cyc;
    end
    if (!hold) begin
      @(posedge clk); #1;
      start = 0;
    end
  endtask

  task automatic wait_done(input int bound);
    int k = 0;
    while (sbq.size() != 0 && k < bound) begin
      @(posedge clk); #2;
      k++;
    end
    if (sbq.size() != 0) begin
      chk("timeout_waiting_done", sbq.size(), 0);
      sbq.delete();
    end
  endtask

  initial begin
    int a_exp;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rx", rx_data, 0);
    chk("rst_sclk", sclk, 0);
    chk("rst_mosi", mosi, 0);
    chk("rst_cs_n", cs_n, 2'b11);
    rst = 0;
    xfer(0, 1, 0, 0, 0, 32'hA5, 32'h0, 1, 1, 0, -1);
    wait_done(100);
    xfer(0, 4, 1, 1, 3, 32'h12345678, 32'hDEADBEEF, 0, 1, 0, -1);
    wait_done(400);
    chk("sclk_idle_cpol1", sclk, 1);
    xfer(1, 2, 0, 1, 2, 32'hC0DE, 32'h5AA5, 0, 1, 0, -1);
    wait_done(200);
    xfer(0, 2, 0, 0, 1, 32'hBEEF, 32'h1234, 0, 1, 0, -1);
    repeat (3) begin
      @(posedge clk); #1;
      start = 1; cs_sel = 1; tx_data = 32'hFFFF0000; cpol = 1; cpha = 1; num_bytes = 3;
      @(posedge clk); #1;
      start = 0;
    end
    chk("busy_during_ignored_start", busy, 1);
    a_exp = last_exp;
    xfer(1, 1, 1, 0, 0, 32'h3C, 32'hC3, 0, 1, 1, a_exp + 1);
    while (cyc < a_exp) begin
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    start = 0;
    wait_done(200);
    xfer(0, 4, 1, 1, 0, 32'hCAFEF00D, 32'h13579BDF, 0, 0, 0, -1);
    repeat (21) @(posedge clk);
    #4;
    rst = 1;
    #1;
    chk("midrst_cs_n", cs_n, 2'b11);
    chk("midrst_sclk", sclk, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_rx", rx_data, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    repeat (40) @(posedge clk);
    #2;
    chk("post_rst_rx", rx_data, 0);
    chk("post_rst_busy", busy, 0);
    xfer(0, 0, 0, 0, 0, 32'h77, 32'h9C, 0, 1, 0, -1);
    wait_done(100);
    xfer(0, 7, 0, 1, 1, 32'h01020304, 32'hF00DCAFE, 0, 1, 0, -1);
    wait_done(300);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
